// File: rtl/cl_frame_gen_if.sv
// Camera Link frame generator bus: run/pattern controls in, framed video out.
// The generator drives the video side through the master modport; a sink
// (capture block or bench) uses the slave modport.
interface cl_frame_gen_if #(
  parameter int PIXEL_WIDTH = 8
);
  logic                   iRUN;
  logic [1:0]             iPATTERN;
  logic [PIXEL_WIDTH-1:0] iLEVEL;
  logic                   oVSYNC;
  logic                   oHSYNC;
  logic                   oDE;
  logic [PIXEL_WIDTH-1:0] oDATA_L;
  logic [PIXEL_WIDTH-1:0] oDATA_R;
  logic                   oFRAME_DONE;
  logic                   oBUSY;
  logic [15:0]            oFRAME_CNT;

  modport master (
    input  iRUN, iPATTERN, iLEVEL,
    output oVSYNC, oHSYNC, oDE, oDATA_L, oDATA_R, oFRAME_DONE, oBUSY, oFRAME_CNT
  );

  modport slave (
    output iRUN, iPATTERN, iLEVEL,
    input  oVSYNC, oHSYNC, oDE, oDATA_L, oDATA_R, oFRAME_DONE, oBUSY, oFRAME_CNT
  );
endinterface

// File: rtl/cl_frame_gen.sv
// Camera Link test-pattern frame generator (two pixels per CCLK).
// Produces VSYNC/HSYNC/DE framing plus even/odd pixel lanes for the capture
// path. All outputs are registered from the current state, so they lag the
// state register by one clock.
// Optional macro CLGEN_FRAME_TAG_EN: first pixel pair of line 0 carries the
// completed-frame count (L = low byte, R = high byte) instead of the pattern.
module cl_frame_gen #(
  parameter int PIXEL_WIDTH = 8,
  parameter int ADDR_WIDTH  = 11,
  parameter int HSIZE       = 640,
  parameter int VSIZE       = 480,
  parameter int HBLANK      = 16,
  parameter int VBLANK      = 32
) (
  input logic CCLK,
  input logic RST_N,
  cl_frame_gen_if.master bus
);

  localparam int BLK_MAX = (HBLANK > VBLANK) ? HBLANK : VBLANK;
  localparam int BLK_W   = $clog2(BLK_MAX + 1);

  localparam logic [BLK_W-1:0]      HB_LAST  = BLK_W'(HBLANK - 1);
  localparam logic [BLK_W-1:0]      VB_LAST  = BLK_W'(VBLANK - 1);
  localparam logic [ADDR_WIDTH-1:0] COL_LAST = ADDR_WIDTH'(HSIZE - 2);
  localparam logic [ADDR_WIDTH-1:0] ROW_LAST = ADDR_WIDTH'(VSIZE - 1);

  typedef enum logic [2:0] {IDLE, LEAD, ACT, HBL, VBL} state_t;

  state_t                  state, state_nxt;
  logic [BLK_W-1:0]        blk, blk_nxt;
  logic [ADDR_WIDTH-1:0]   col, col_nxt;
  logic [ADDR_WIDTH-1:0]   row, row_nxt;
  logic [1:0]              pat, pat_nxt;

  logic                    vsync_n, vld_n, done_n, busy_n;
  logic [2*PIXEL_WIDTH-1:0] px_n;

  logic                    vsync_p1, vld_p1, done_p1, busy_p1;
  logic [PIXEL_WIDTH-1:0]  data_l_p1, data_r_p1;
  logic [15:0]             cnt_p1;

  // Pixel pair {L, R} for even column c on row r; c is always even, so c+1
  // is just c with bit 0 set.
  function automatic logic [2*PIXEL_WIDTH-1:0] pattern_px(
    input logic [1:0]             sel,
    input logic [ADDR_WIDTH-1:0]  c,
    input logic [ADDR_WIDTH-1:0]  r,
    input logic [PIXEL_WIDTH-1:0] lvl
  );
    logic [ADDR_WIDTH-1:0]  c1;
    logic [PIXEL_WIDTH-1:0] chk;
    c1  = {c[ADDR_WIDTH-1:1], 1'b1};
    chk = (c[3] ^ r[3]) ? '1 : '0;
    case (sel)
      2'd0:    return {c[PIXEL_WIDTH-1:0], c1[PIXEL_WIDTH-1:0]};
      2'd1:    return {r[PIXEL_WIDTH-1:0], r[PIXEL_WIDTH-1:0]};
      2'd2:    return {chk, chk};
      default: return {lvl, lvl};
    endcase
  endfunction

  // State register, position counters and the per-frame pattern latch.
  always_ff @(posedge CCLK) begin
    if (!RST_N) begin
      state <= IDLE;
      blk   <= '0;
      col   <= '0;
      row   <= '0;
      pat   <= '0;
    end else begin
      state <= state_nxt;
      blk   <= blk_nxt;
      col   <= col_nxt;
      row   <= row_nxt;
      pat   <= pat_nxt;
    end
  end

  // Next-state sequencing: lead blank, then VSIZE x (active + blank), then VBL.
  always_comb begin
    state_nxt = state;
    blk_nxt   = blk;
    col_nxt   = col;
    row_nxt   = row;
    pat_nxt   = pat;
    case (state)
      IDLE: begin
        if (bus.iRUN) begin
          state_nxt = LEAD;
          pat_nxt   = bus.iPATTERN;
          blk_nxt   = '0;
          col_nxt   = '0;
          row_nxt   = '0;
        end
      end
      LEAD: begin
        if (blk == HB_LAST) begin
          state_nxt = ACT;
          blk_nxt   = '0;
          col_nxt   = '0;
        end else begin
          blk_nxt = blk + 1'b1;
        end
      end
      ACT: begin
        if (col == COL_LAST) begin
          state_nxt = HBL;
          col_nxt   = '0;
        end else begin
          col_nxt = col + 2'd2;
        end
      end
      HBL: begin
        if (blk == HB_LAST) begin
          blk_nxt = '0;
          if (row == ROW_LAST) begin
            state_nxt = VBL;
          end else begin
            row_nxt   = row + 1'b1;
            state_nxt = ACT;
          end
        end else begin
          blk_nxt = blk + 1'b1;
        end
      end
      VBL: begin
        if (blk == VB_LAST) begin
          blk_nxt = '0;
          row_nxt = '0;
          if (bus.iRUN) begin
            state_nxt = LEAD;
            pat_nxt   = bus.iPATTERN;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          blk_nxt = blk + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from the current state; data is forced to 0 outside DE.
  always_comb begin
    vsync_n = (state == LEAD) || (state == ACT) || (state == HBL);
    vld_n   = (state == ACT);
    done_n  = (state == VBL) && (blk == '0);
    busy_n  = (state != IDLE);
    px_n    = '0;
    if (state == ACT) begin
      px_n = pattern_px(pat, col, row, bus.iLEVEL);
`ifdef CLGEN_FRAME_TAG_EN
      if (row == '0 && col == '0)
        px_n = {PIXEL_WIDTH'(cnt_p1[7:0]), PIXEL_WIDTH'(cnt_p1[15:8])};
`endif
    end
  end

  // Output register stage; frame count steps on the frame-done edge.
  always_ff @(posedge CCLK) begin
    if (!RST_N) begin
      vsync_p1  <= 1'b0;
      vld_p1    <= 1'b0;
      done_p1   <= 1'b0;
      busy_p1   <= 1'b0;
      data_l_p1 <= '0;
      data_r_p1 <= '0;
      cnt_p1    <= '0;
    end else begin
      vsync_p1  <= vsync_n;
      vld_p1    <= vld_n;
      done_p1   <= done_n;
      busy_p1   <= busy_n;
      data_l_p1 <= px_n[2*PIXEL_WIDTH-1:PIXEL_WIDTH];
      data_r_p1 <= px_n[PIXEL_WIDTH-1:0];
      cnt_p1    <= cnt_p1 + {15'd0, done_n};
    end
  end

  assign bus.oVSYNC      = vsync_p1;
  assign bus.oHSYNC      = vld_p1;
  assign bus.oDE         = vld_p1;
  assign bus.oDATA_L     = data_l_p1;
  assign bus.oDATA_R     = data_r_p1;
  assign bus.oFRAME_DONE = done_p1;
  assign bus.oBUSY       = busy_p1;
  assign bus.oFRAME_CNT  = cnt_p1;

endmodule

// File: tb/tb_cl_frame_gen.sv
// Directed bench for cl_frame_gen: small 8x4 frame for framing/pattern/run
// control/reset, and a 32x16 frame for the checker pattern.
module tb_cl_frame_gen;
  localparam int PW = 8;

  logic CCLK = 1'b0;
  logic RST_N;
  logic RST_N_B;

  always #5 CCLK = ~CCLK;

  cl_frame_gen_if #(.PIXEL_WIDTH(PW)) bus_a ();
  cl_frame_gen_if #(.PIXEL_WIDTH(PW)) bus_b ();

  cl_frame_gen #(.PIXEL_WIDTH(PW), .ADDR_WIDTH(11), .HSIZE(8), .VSIZE(4),
                 .HBLANK(3), .VBLANK(5))
    u_dut (.CCLK(CCLK), .RST_N(RST_N), .bus(bus_a.master));

  cl_frame_gen #(.PIXEL_WIDTH(PW), .ADDR_WIDTH(11), .HSIZE(32), .VSIZE(16),
                 .HBLANK(3), .VBLANK(5))
    u_chk (.CCLK(CCLK), .RST_N(RST_N_B), .bus(bus_b.master));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CCLK);
    #1;
  endtask

  task automatic chk_all_zero(input string pfx);
    chk_val({pfx, " vsync"}, 32'(bus_a.oVSYNC), 0);
    chk_val({pfx, " hsync"}, 32'(bus_a.oHSYNC), 0);
    chk_val({pfx, " de"},    32'(bus_a.oDE), 0);
    chk_val({pfx, " dl"},    32'(bus_a.oDATA_L), 0);
    chk_val({pfx, " dr"},    32'(bus_a.oDATA_R), 0);
    chk_val({pfx, " done"},  32'(bus_a.oFRAME_DONE), 0);
    chk_val({pfx, " busy"},  32'(bus_a.oBUSY), 0);
    chk_val({pfx, " cnt"},   32'(bus_a.oFRAME_CNT), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f, p, q, ln, pi, pf;
    logic       e_v, e_de, e_done, e_busy;
    logic [7:0] e_l, e_r;
    int         e_cnt;
    int         waited, burst, pix, hi_len;
    logic       prev_de;

    RST_N = 1'b0;
    RST_N_B = 1'b0;
    bus_a.iRUN = 1'b0; bus_a.iPATTERN = 2'd0; bus_a.iLEVEL = 8'h00;
    bus_b.iRUN = 1'b0; bus_b.iPATTERN = 2'd0; bus_b.iLEVEL = 8'h00;
    step();
    step();
    chk_all_zero("reset");

    RST_N = 1'b1;
    RST_N_B = 1'b1;
    step();
    step();
    chk_val("idle vsync", 32'(bus_a.oVSYNC), 0);
    chk_val("idle busy",  32'(bus_a.oBUSY), 0);

    // Start: iRUN sampled at edge k, VSYNC high from edge k+1.
    bus_a.iRUN = 1'b1;
    bus_a.iPATTERN = 2'd0;
    step();
    chk_val("start k vsync", 32'(bus_a.oVSYNC), 0);
    chk_val("start k busy",  32'(bus_a.oBUSY), 0);
    step();

    // Frame period 36: VSYNC high p=0..30, lines start at p=3,10,17,24.
    // Frames 0,1 pattern 0; frame 2 pattern 1; frame 3 level 0x5A; then idle.
    for (int c = 0; c < 4 * 36 + 20; c++) begin
      f = c / 36;
      p = c % 36;
      e_v = (f < 4) && (p < 31);
      e_de = 1'b0;
      e_l = 8'h00;
      e_r = 8'h00;
      if (f < 4 && p >= 3 && p < 31) begin
        q  = (p - 3) % 7;
        ln = (p - 3) / 7;
        if (q < 4) begin
          e_de = 1'b1;
          pi = q;
          pf = (f < 2) ? 0 : (f == 2) ? 1 : 3;
          case (pf)
            0: begin e_l = 8'(2 * pi); e_r = 8'(2 * pi + 1); end
            1: begin e_l = 8'(ln); e_r = 8'(ln); end
            default: begin e_l = 8'h5A; e_r = 8'h5A; end
          endcase
`ifdef CLGEN_FRAME_TAG_EN
          if (ln == 0 && pi == 0) begin e_l = 8'(f); e_r = 8'h00; end
`endif
        end
      end
      e_done = (f < 4) && (p == 31);
      e_cnt  = (f >= 4) ? 4 : ((p >= 31) ? f + 1 : f);
      e_busy = (f < 4);
      chk_val($sformatf("vsync c%0d", c), 32'(bus_a.oVSYNC), 32'(e_v));
      chk_val($sformatf("de c%0d", c),    32'(bus_a.oDE), 32'(e_de));
      chk_val($sformatf("hsync c%0d", c), 32'(bus_a.oHSYNC), 32'(e_de));
      chk_val($sformatf("dl c%0d", c),    32'(bus_a.oDATA_L), 32'(e_l));
      chk_val($sformatf("dr c%0d", c),    32'(bus_a.oDATA_R), 32'(e_r));
      chk_val($sformatf("done c%0d", c),  32'(bus_a.oFRAME_DONE), 32'(e_done));
      chk_val($sformatf("cnt c%0d", c),   32'(bus_a.oFRAME_CNT), 32'(e_cnt));
      chk_val($sformatf("busy c%0d", c),  32'(bus_a.oBUSY), 32'(e_busy));
      if (c == 36 + 10) bus_a.iPATTERN = 2'd1;
      if (c == 72 + 10) begin bus_a.iPATTERN = 2'd3; bus_a.iLEVEL = 8'h5A; end
      if (c == 108 + 17) bus_a.iRUN = 1'b0;
      step();
    end

    // Reset during ACT: all outputs clear on the next edge, restart in 1 clock.
    bus_a.iPATTERN = 2'd0;
    bus_a.iRUN = 1'b1;
    waited = 0;
    while (!bus_a.oDE && waited < 20) begin
      step();
      waited++;
    end
    if (!bus_a.oDE) chk_val("wait de timeout", 0, 1);
    step();
    RST_N = 1'b0;
    step();
    chk_all_zero("midreset");
    RST_N = 1'b1;
    step();
    chk_val("restart k vsync",  32'(bus_a.oVSYNC), 0);
    step();
    chk_val("restart k1 vsync", 32'(bus_a.oVSYNC), 1);
    chk_val("restart k1 busy",  32'(bus_a.oBUSY), 1);
    bus_a.iRUN = 1'b0;

    // Checker pattern on the 32x16 instance.
    bus_b.iPATTERN = 2'd2;
    bus_b.iRUN = 1'b1;
    waited = 0;
    while (!bus_b.oVSYNC && waited < 10) begin
      step();
      waited++;
    end
    if (!bus_b.oVSYNC) chk_val("wait vsync b timeout", 0, 1);
    bus_b.iRUN = 1'b0;
    burst = -1;
    pix = 0;
    prev_de = 1'b0;
    hi_len = 0;
    while (bus_b.oVSYNC && hi_len < 400) begin
      if (bus_b.oDE && !prev_de) begin
        burst++;
        pix = 0;
      end
      if (!bus_b.oDE && prev_de)
        chk_val($sformatf("b burst%0d len", burst), 32'(pix), 16);
      if (bus_b.oDE) begin
        if ((burst == 0 || burst == 8) && pix < 8) begin
          e_l = (((pix >= 4) ? 1 : 0) ^ ((burst == 8) ? 1 : 0)) != 0 ? 8'hFF : 8'h00;
          chk_val($sformatf("chk L line%0d pair%0d", burst, pix), 32'(bus_b.oDATA_L), 32'(e_l));
          chk_val($sformatf("chk R line%0d pair%0d", burst, pix), 32'(bus_b.oDATA_R), 32'(e_l));
        end
        pix++;
      end
      prev_de = bus_b.oDE;
      hi_len++;
      step();
    end
    chk_val("b vsync high", 32'(hi_len), 307);
    chk_val("b lines", 32'(burst + 1), 16);
    chk_val("b done pulse", 32'(bus_b.oFRAME_DONE), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
